ddp_segment_realigner: RTL and testbench

//  Parametrised DDP segment cutter between the DDP ingress FIFO and the per-queue RecvBuffer / HeaderProc.

---
 rtl/ddp_segment_realigner.sv | 247 ++++++++++++++++++++++++
 tb/tb_ddp_segment_realigner.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddp_segment_realigner.sv
// DDP segment cutter: strips the SOP header, realigns SEND payload to beats.
// Optional DDP_LEN_CHECK_EN adds a pushed-beat counter driving hdrLenErr.
`ifndef SEND_OPCODE
`define SEND_OPCODE 4'h3
`endif

module ddp_segment_realigner #(
  parameter int DATA_W    = 256,
  parameter int HDR_BYTES = 11,
  parameter int NUM_Q     = 16,
  parameter int CNT_W     = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic                        inSop,
  input  logic                        inEop,
  input  logic [$clog2(DATA_W/8):0]   inBytes,
  input  logic [DATA_W-1:0]           inData,
  output logic                        pushValid,
  input  logic                        pushReady,
  output logic [$clog2(NUM_Q)-1:0]    pushQN,
  output logic [DATA_W-1:0]           pushData,
  output logic [$clog2(DATA_W/8):0]   pushBytes,
  output logic                        pushLast,
  output logic                        hdrValid,
  output logic [7:0]                  hdrCtrl,
  output logic [55:0]                 hdrRdmap,
  output logic                        hdrLenErr,
  output logic                        errSop
);

  localparam int DB   = DATA_W / 8;
  localparam int BW   = $clog2(DB) + 1;
  localparam int TW   = BW + 1;
  localparam int QN_W = $clog2(NUM_Q);
  localparam int LSB  = DATA_W - 32;
  localparam logic [TW-1:0] DBT = TW'(DB);
  localparam logic [TW-1:0] HBT = TW'(HDR_BYTES);
  localparam logic [TW-1:0] PT  = TW'(DB - HDR_BYTES);
  localparam logic [BW-1:0] DBB = BW'(DB);

  typedef enum logic [1:0] {IDLE, BODY, FLUSH, DROP} state_t;

  state_t state, stateNext;

  logic [DATA_W-1:0]   carryData, carryNext;
  logic [TW-1:0]       carryCnt, cntNext;
  logic [7:0]          ctrlQ;
  logic [55:0]         rdmapQ;
  logic [QN_W-1:0]     qnQ;

  logic                outFree, accept, beatSend;
  logic [QN_W-1:0]     beatQn;
  logic [TW-1:0]       inBytesT, sopLen, total;
  logic [DATA_W-1:0]   beatData, sopPay;
  logic [2*DATA_W-1:0] wide;

  logic                emit, emitLast, hdrFire, hdrFromBeat;
  logic                sopErr, latchHdr;
  logic [DATA_W-1:0]   emitData;
  logic [BW-1:0]       emitBytes;
  logic [QN_W-1:0]     emitQn;

  function automatic logic [DATA_W-1:0] topMask(input logic [TW-1:0] n);
    topMask = ~({DATA_W{1'b1}} >> {n, 3'b000});
  endfunction

  assign outFree  = ~pushValid | pushReady;
  assign inReady  = outFree & (state != FLUSH);
  assign accept   = inValid & inReady;
  assign beatSend = (inData[DATA_W-13 -: 4] == `SEND_OPCODE);
  assign beatQn   = inData[LSB+9 +: QN_W];
  assign inBytesT = {1'b0, inBytes};
  assign total    = carryCnt + inBytesT;
  assign beatData = inData & topMask(inBytesT);
  assign sopLen   = !inEop ? PT :
                    (inBytesT > HBT) ? inBytesT - HBT : '0;
  assign sopPay   = (inData << (8 * HDR_BYTES)) & topMask(sopLen);
  // carry sits at the top, the new beat is appended right after it
  assign wide     = {carryData, {DATA_W{1'b0}}}
                  | ({beatData, {DATA_W{1'b0}}} >> {carryCnt, 3'b000});

  always_comb begin
    stateNext   = state;
    carryNext   = carryData;
    cntNext     = carryCnt;
    emit        = 1'b0;
    emitData    = '0;
    emitBytes   = '0;
    emitLast    = 1'b0;
    emitQn      = qnQ;
    hdrFire     = 1'b0;
    hdrFromBeat = 1'b0;
    sopErr      = 1'b0;
    latchHdr    = 1'b0;
    if (state == FLUSH) begin
      if (outFree) begin
        emit      = 1'b1;
        emitData  = carryData;
        emitBytes = carryCnt[BW-1:0];
        emitLast  = 1'b1;
        stateNext = IDLE;
        carryNext = '0;
        cntNext   = '0;
      end
    end else if (accept) begin
      if (inSop) begin
        sopErr    = (state != IDLE);
        latchHdr  = 1'b1;
        emitQn    = beatQn;
        carryNext = sopPay;
        cntNext   = sopLen;
        if (inEop) begin
          hdrFire     = 1'b1;
          hdrFromBeat = 1'b1;
          stateNext   = IDLE;
          carryNext   = '0;
          cntNext     = '0;
          if (beatSend && sopLen != '0) begin
            emit      = 1'b1;
            emitData  = sopPay;
            emitBytes = sopLen[BW-1:0];
            emitLast  = 1'b1;
          end
        end else begin
          stateNext = beatSend ? BODY : DROP;
        end
      end else begin
        unique case (1'b1)
          state == DROP: begin
            if (inEop) begin
              hdrFire   = 1'b1;
              stateNext = IDLE;
            end
          end
          state == BODY: begin
            if (total >= DBT) begin
              emit      = 1'b1;
              emitData  = wide[2*DATA_W-1 -: DATA_W];
              emitBytes = DBB;
              carryNext = wide[DATA_W-1:0];
              cntNext   = total - DBT;
            end else begin
              carryNext = wide[2*DATA_W-1 -: DATA_W];
              cntNext   = total;
            end
            if (inEop) begin
              hdrFire = 1'b1;
              if (total > DBT) begin
                stateNext = FLUSH;
              end else begin
                stateNext = IDLE;
                carryNext = '0;
                cntNext   = '0;
                if (total != '0) begin
                  emit      = 1'b1;
                  emitData  = wide[2*DATA_W-1 -: DATA_W];
                  emitBytes = total[BW-1:0];
                  emitLast  = 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      carryData <= '0;
      carryCnt  <= '0;
      ctrlQ     <= '0;
      rdmapQ    <= '0;
      qnQ       <= '0;
      pushValid <= 1'b0;
      pushData  <= '0;
      pushBytes <= '0;
      pushLast  <= 1'b0;
      pushQN    <= '0;
      hdrValid  <= 1'b0;
      hdrCtrl   <= '0;
      hdrRdmap  <= '0;
      errSop    <= 1'b0;
    end else begin
      state     <= stateNext;
      carryData <= carryNext;
      carryCnt  <= cntNext;
      hdrValid  <= hdrFire;
      errSop    <= sopErr;
      if (latchHdr) begin
        ctrlQ  <= inData[DATA_W-9 -: 8];
        rdmapQ <= inData[DATA_W-33 -: 56];
        qnQ    <= beatQn;
      end
      if (hdrFire) begin
        hdrCtrl  <= hdrFromBeat ? inData[DATA_W-9 -: 8] : ctrlQ;
        hdrRdmap <= hdrFromBeat ? inData[DATA_W-33 -: 56] : rdmapQ;
      end
      if (outFree) begin
        pushValid <= emit;
        if (emit) begin
          pushData  <= emitData;
          pushBytes <= emitBytes;
          pushLast  <= emitLast;
          pushQN    <= emitQn;
        end
      end
    end
  end

`ifdef DDP_LEN_CHECK_EN
  logic [CNT_W-1:0] segCnt, segBase, segNext, segTot, lenQ, lenRef;

  function automatic logic [CNT_W-1:0] satInc(
    input logic [CNT_W-1:0] a, input logic inc);
    satInc = (inc && a != '1) ? a + 1'b1 : a;
  endfunction

  // a pending FLUSH beat belongs to this segment's count
  always_comb begin
    segBase = (accept && inSop) ? '0 : segCnt;
    segNext = satInc(segBase, emit);
    segTot  = satInc(segNext, stateNext == FLUSH);
    lenRef  = hdrFromBeat ? inData[LSB +: CNT_W] : lenQ;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      segCnt    <= '0;
      lenQ      <= '0;
      hdrLenErr <= 1'b0;
    end else begin
      segCnt    <= segNext;
      hdrLenErr <= hdrFire & (segTot != lenRef);
      if (latchHdr) lenQ <= inData[LSB +: CNT_W];
    end
  end
`else
  assign hdrLenErr = 1'b0;
`endif

endmodule

// File: tb/tb_ddp_segment_realigner.sv
// Directed bench for ddp_segment_realigner: segment table plus
// backpressure, mid-segment SOP and mid-segment reset sequences.
module tb_ddp_segment_realigner;

  localparam int DW = 256;
  localparam int DB = 32;
`ifdef SEND_OPCODE
  localparam logic [3:0] SENDOP = `SEND_OPCODE;
`else
  localparam logic [3:0] SENDOP = 4'h3;
`endif
  localparam logic [3:0] REQOP = 4'h1;

  logic          clock = 1'b0;
  logic          reset;
  logic          inValid, inReady, inSop, inEop;
  logic [5:0]    inBytes;
  logic [DW-1:0] inData;
  logic          pushValid, pushReady, pushLast;
  logic [3:0]    pushQN;
  logic [DW-1:0] pushData;
  logic [5:0]    pushBytes;
  logic          hdrValid, hdrLenErr, errSop;
  logic [7:0]    hdrCtrl;
  logic [55:0]   hdrRdmap;

  ddp_segment_realigner dut (
    .clock(clock), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .inSop(inSop), .inEop(inEop),
    .inBytes(inBytes), .inData(inData),
    .pushValid(pushValid), .pushReady(pushReady),
    .pushQN(pushQN), .pushData(pushData),
    .pushBytes(pushBytes), .pushLast(pushLast),
    .hdrValid(hdrValid), .hdrCtrl(hdrCtrl),
    .hdrRdmap(hdrRdmap), .hdrLenErr(hdrLenErr),
    .errSop(errSop)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  int         pB[$];
  int         pL[$];
  int         pQ[$];
  int         hdrCnt = 0;
  int         errCnt = 0;
  int         rdyLow = 0;
  int         zeroBad = 0;
  logic [7:0]  lastCtrl = '0;
  logic [55:0] lastRdmap = '0;
  logic        lastErr = 1'b0;
  logic [7:0]  pv = 8'h00;

  always @(negedge clock) begin
    if (pushValid && pushReady) begin
      for (int i = 0; i < DB; i++) begin
        if (i < int'(pushBytes)) gotQ.push_back(pushData[DW-1-8*i -: 8]);
        else if (pushData[DW-1-8*i -: 8] != 8'h00) zeroBad++;
      end
      pB.push_back(int'(pushBytes));
      pL.push_back(int'(pushLast));
      pQ.push_back(int'(pushQN));
    end
    if (hdrValid) begin
      hdrCnt++;
      lastCtrl  = hdrCtrl;
      lastRdmap = hdrRdmap;
      lastErr   = hdrLenErr;
    end
    if (errSop) errCnt++;
    if (!inReady) rdyLow++;
  end

  task automatic check(input string name, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic sop, input logic eop,
                      input logic [5:0] nb, input logic [DW-1:0] d);
    logic r;
    logic done;
    done    = 1'b0;
    inValid = 1'b1;
    inSop   = sop;
    inEop   = eop;
    inBytes = nb;
    inData  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      r = inReady;
      @(posedge clock);
      #1;
      if (r) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("beatTimeout", 0, 1);
    inValid = 1'b0;
    inSop   = 1'b0;
    inEop   = 1'b0;
  endtask

  task automatic sendSeg(input logic [3:0] op, input int qn, input int len,
                         input int nBeats, input int lastB,
                         input logic [55:0] rd, input int stopAfter);
    logic [87:0]   hdr;
    logic [15:0]   ddp;
    logic [DW-1:0] d;
    logic [7:0]    b;
    logic          sop, eop;
    int            nb;
    ddp = 16'((qn << 9) | len);
    hdr = {8'h41, 4'h4, op, ddp, rd};
    for (int i = 0; i < nBeats && i < stopAfter; i++) begin
      sop = (i == 0);
      eop = (i == nBeats - 1);
      nb  = eop ? lastB : DB;
      for (int j = 0; j < DB; j++) begin
        if (j >= nb) b = 8'hEE;
        else if (sop && j < 11) b = hdr[87-8*j -: 8];
        else begin
          b  = pv;
          pv = pv + 8'h01;
          if (op == SENDOP) expQ.push_back(b);
        end
        d[DW-1-8*j -: 8] = b;
      end
      beat(sop, eop, 6'(nb), d);
    end
  endtask

  task automatic checkPush(input int idx, input int bytes,
                           input int last, input int qn);
    check("pushBytes", idx < pB.size() ? pB[idx] : -1, bytes);
    check("pushLast",  idx < pL.size() ? pL[idx] : -1, last);
    check("pushQN",    idx < pQ.size() ? pQ[idx] : -1, qn);
  endtask

  task automatic checkPayload(input int g0, input int e0);
    int mis;
    int n;
    mis = 0;
    n   = gotQ.size() - g0;
    check("payloadLen", n, expQ.size() - e0);
    for (int k = 0; k < n && e0 + k < expQ.size(); k++)
      if (gotQ[g0+k] !== expQ[e0+k]) mis++;
    check("payloadData", mis, 0);
  endtask

  typedef struct {
    logic [3:0] op;
    int qn;
    int len;
    int nBeats;
    int lastB;
    int nPush;
    int b0;
    int b1;
    int b2;
    int flush;
  } vec_t;

  vec_t vecs[9];

  task automatic runVec(input int v);
    int p0 = pB.size();
    int g0 = gotQ.size();
    int e0 = expQ.size();
    int h0 = hdrCnt;
    int r0 = rdyLow;
    int z0 = zeroBad;
    int s0 = errCnt;
    int eb;
    logic [55:0] rd;
    logic expErr;
    rd = 56'h11223344556600 + 56'(v);
`ifdef DDP_LEN_CHECK_EN
    expErr = (vecs[v].nPush != vecs[v].len);
`else
    expErr = 1'b0;
`endif
    sendSeg(vecs[v].op, vecs[v].qn, vecs[v].len, vecs[v].nBeats,
            vecs[v].lastB, rd, 100);
    idle(8);
    check("nPush", pB.size() - p0, vecs[v].nPush);
    for (int i = 0; i < vecs[v].nPush; i++) begin
      eb = (i == 0) ? vecs[v].b0 : (i == 1) ? vecs[v].b1 : vecs[v].b2;
      checkPush(p0 + i, eb, (i == vecs[v].nPush - 1) ? 1 : 0, vecs[v].qn);
    end
    checkPayload(g0, e0);
    check("zeroTail", zeroBad - z0, 0);
    check("hdrCount", hdrCnt - h0, 1);
    check("hdrCtrl", lastCtrl, {4'h4, vecs[v].op});
    check("hdrRdmap", lastRdmap, rd);
    check("hdrLenErr", lastErr, expErr);
    check("inReadyLow", rdyLow - r0, vecs[v].flush);
    check("errSopQuiet", errCnt - s0, 0);
  endtask

  task automatic seqBackpressure();
    int p0 = pB.size();
    int g0 = gotQ.size();
    int e0 = expQ.size();
    logic [DW-1:0] sd;
    logic [5:0]    sb;
    logic          seen;
    pushReady = 1'b0;
    fork
      sendSeg(SENDOP, 3, 3, 4, 10, 56'hABCDEF, 100);
      begin
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clock);
          if (pushValid) begin
            seen = 1'b1;
            break;
          end
        end
        check("stallSeen", seen, 1);
        sd = pushData;
        sb = pushBytes;
        check("stallBytes0", sb, 32);
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          check("stallValid", pushValid, 1);
          check("stallHold", (pushData === sd && pushBytes === sb) ? 1 : 0, 1);
          check("stallInReady", inReady, 0);
        end
        @(posedge clock);
        #1;
        pushReady = 1'b1;
      end
    join
    idle(8);
    check("bpNPush", pB.size() - p0, 3);
    checkPush(p0, 32, 0, 3);
    checkPush(p0 + 1, 32, 0, 3);
    checkPush(p0 + 2, 31, 1, 3);
    checkPayload(g0, e0);
  endtask

  task automatic seqSopMid();
    int p0 = pB.size();
    int g0 = gotQ.size();
    int e0 = expQ.size();
    int h0 = hdrCnt;
    int s0 = errCnt;
    sendSeg(SENDOP, 4, 4, 4, 10, 56'h0000AA, 2);
    repeat (21) void'(expQ.pop_back());
    sendSeg(SENDOP, 6, 3, 4, 10, 56'h0000BB, 100);
    idle(8);
    check("sopErrCount", errCnt - s0, 1);
    check("sopHdrCount", hdrCnt - h0, 1);
    check("sopHdrRdmap", lastRdmap, 56'h0000BB);
    check("sopNPush", pB.size() - p0, 4);
    checkPush(p0, 32, 0, 4);
    checkPush(p0 + 1, 32, 0, 6);
    checkPush(p0 + 2, 32, 0, 6);
    checkPush(p0 + 3, 31, 1, 6);
    checkPayload(g0, e0);
  endtask

  task automatic seqReset();
    int p0 = pB.size();
    int h0 = hdrCnt;
    int g0;
    int e0;
    sendSeg(SENDOP, 3, 3, 4, 10, 56'h0000CC, 2);
    reset = 1'b0;
    #1;
    check("rstPushValid", pushValid, 0);
    idle(2);
    reset = 1'b1;
    idle(6);
    check("rstNoPush", pB.size() - p0, 0);
    check("rstNoHdr", hdrCnt - h0, 0);
    p0 = pB.size();
    g0 = gotQ.size();
    e0 = expQ.size();
    sendSeg(SENDOP, 7, 1, 1, 20, 56'h0000DD, 100);
    idle(6);
    check("rstNextNPush", pB.size() - p0, 1);
    checkPush(p0, 9, 1, 7);
    checkPayload(g0, e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{SENDOP, 5, 3, 4, 10, 3, 32, 32, 31, 0};
    vecs[1] = '{SENDOP, 5, 4, 4, 10, 3, 32, 32, 31, 0};
    vecs[2] = '{SENDOP, 2, 2, 2, 20, 2, 32, 9, 0, 1};
    vecs[3] = '{REQOP, 1, 0, 3, 16, 0, 0, 0, 0, 0};
    vecs[4] = '{SENDOP, 7, 1, 1, 20, 1, 9, 0, 0, 0};
    vecs[5] = '{SENDOP, 0, 0, 1, 11, 0, 0, 0, 0, 0};
    vecs[6] = '{SENDOP, 15, 1, 2, 11, 1, 32, 0, 0, 0};
    vecs[7] = '{SENDOP, 9, 2, 2, 32, 2, 32, 21, 0, 1};
    vecs[8] = '{4'h5, 11, 0, 1, 30, 0, 0, 0, 0, 0};

    reset     = 1'b0;
    inValid   = 1'b0;
    inSop     = 1'b0;
    inEop     = 1'b0;
    inBytes   = '0;
    inData    = '0;
    pushReady = 1'b1;
    #12;
    check("rstPushValid", pushValid, 0);
    check("rstPushLast", pushLast, 0);
    check("rstPushBytes", pushBytes, 0);
    check("rstHdrValid", hdrValid, 0);
    check("rstHdrCtrl", hdrCtrl, 0);
    check("rstHdrLenErr", hdrLenErr, 0);
    check("rstErrSop", errSop, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    for (int v = 0; v < 9; v++) runVec(v);
    seqBackpressure();
    seqSopMid();
    seqReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
